// File: rtl/spi_resp_pkg.sv
// Shared constants and FSM state type for the SPI serial-RAM responder.
package spi_resp_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int DUMMY_BITS = 8;
  localparam int ADDR_BITS  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI pin bundle plus responder status strobes, seen from both ends of the link.
interface spi_mem_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic wr_strobe;
  logic cmd_err;

  // No valid/ready flow control: wr_strobe and cmd_err are single-cycle
  // event pulses that the observer must sample every clk; they cannot stall.
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe, busy, wr_strobe, cmd_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe, busy, wr_strobe, cmd_err
  );
endinterface

// File: rtl/spi_resp_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection in the clk domain.
module spi_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // cs_n history resets to "asserted" so a reset taken while the initiator
  // holds cs_n low cannot fake a falling edge; a fresh fall is required.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial-RAM responder: READ 0x03 / WRITE 0x02, 24-bit address, auto-increment.
// Define SPI_RESP_FAST_READ_EN to also accept FAST READ 0x0B with 8 dummy clocks.
module spi_mem_responder
  import spi_resp_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  spi_mem_responder_if.slave bus,
  output state_t state_dbg
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  spi_resp_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (bus.spi_sclk),
    .cs_n      (bus.spi_cs_n),
    .mosi      (bus.spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .mosi_s    (mosi_s)
  );

  state_t            state, state_next;
  logic              cmd_err_q, cmd_err_next;
  logic [4:0]        bit_cnt;
  logic [6:0]        cmd_sh, rx_sh;
  logic [7:0]        cmd_byte, op_q, tx_sh, wr_data;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        tx_cnt;
  logic              load_pend, wr_pend, miso_q;
  logic              last_cmd_bit, last_addr_bit;
  logic [7:0]        mem [DEPTH];

  assign cmd_byte      = {cmd_sh, mosi_s};
  assign last_cmd_bit  = (bit_cnt == 5'd7);
  assign last_addr_bit = (bit_cnt == 5'(ADDR_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_err_q <= cmd_err_next;
    end
  end

  // cs_n rise has priority over any sclk edge seen in the same cycle.
  always_comb begin
    state_next   = state;
    cmd_err_next = 1'b0;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && last_cmd_bit) begin
            case (cmd_byte)
              OP_READ, OP_WRITE: state_next = ST_ADDR;
`ifdef SPI_RESP_FAST_READ_EN
              OP_FAST_READ:      state_next = ST_ADDR;
`endif
              default: begin
                state_next   = ST_IGNORE;
                cmd_err_next = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (sclk_rise && last_addr_bit) begin
            if (op_q == OP_WRITE)          state_next = ST_WRITE;
            else if (op_q == OP_FAST_READ) state_next = ST_DUMMY;
            else                           state_next = ST_READ;
          end
        end
        ST_DUMMY: if (sclk_rise && bit_cnt == 5'(DUMMY_BITS - 1)) state_next = ST_READ;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      cmd_sh    <= '0;
      rx_sh     <= '0;
      op_q      <= '0;
      tx_sh     <= '0;
      wr_data   <= '0;
      addr      <= '0;
      tx_cnt    <= '0;
      load_pend <= 1'b0;
      wr_pend   <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) addr <= addr + ADDR_W'(1);
      if (cs_rise || state == ST_IDLE) begin
        bit_cnt   <= '0;
        tx_cnt    <= '0;
        load_pend <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        case (state)
          ST_CMD: if (sclk_rise) begin
            cmd_sh  <= cmd_byte[6:0];
            bit_cnt <= last_cmd_bit ? 5'd0 : bit_cnt + 5'd1;
            if (last_cmd_bit) op_q <= cmd_byte;
          end
          // Only the low ADDR_W address bits survive the shift.
          ST_ADDR: if (sclk_rise) begin
            addr    <= {addr[ADDR_W-2:0], mosi_s};
            bit_cnt <= last_addr_bit ? 5'd0 : bit_cnt + 5'd1;
          end
          ST_DUMMY: if (sclk_rise) bit_cnt <= bit_cnt + 5'd1;
          ST_WRITE: if (sclk_rise) begin
            rx_sh <= {rx_sh[5:0], mosi_s};
            if (last_cmd_bit) begin
              bit_cnt <= '0;
              wr_data <= {rx_sh, mosi_s};
              wr_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_READ: begin
            if (load_pend) begin
              tx_sh     <= mem[addr];
              addr      <= addr + ADDR_W'(1);
              load_pend <= 1'b0;
              tx_cnt    <= '0;
            end else if (sclk_fall) begin
              miso_q <= tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
              tx_cnt <= tx_cnt + 3'd1;
              if (tx_cnt == 3'd7) load_pend <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state != ST_READ && state_next == ST_READ) load_pend <= 1'b1;
      end
    end
  end

  // Storage is deliberately outside reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && wr_pend) mem[addr] <= wr_data;
  end

  assign bus.spi_miso_oe = (state == ST_READ);
  assign bus.spi_miso    = miso_q & bus.spi_miso_oe;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.wr_strobe   = wr_pend;
  assign bus.cmd_err     = cmd_err_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: write/read, wrap, bad opcode, aborts, reset, fast read.
module tb_spi_mem_responder;
  import spi_resp_pkg::*;

  localparam int HALF = 8;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t state_dbg;

  spi_mem_responder_if bus();

  spi_mem_responder #(.DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;
  int leak_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wr_strobe === 1'b1) wr_cnt++;
      if (bus.cmd_err === 1'b1) err_cnt++;
      if (bus.spi_miso_oe === 1'b1) oe_cnt++;
      if (bus.spi_miso_oe !== 1'b1 && bus.spi_miso !== 1'b0) leak_cnt++;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = tx[i];
      wait_clk(HALF);
      rx[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      wait_clk(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    bus.spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(4);
    bus.spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(op, rx);
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic do_write(input logic [23:0] a);
    logic [7:0] rx;
    cs_begin();
    send_hdr(OP_WRITE, a);
    while (tx_q.size() > 0) spi_byte(tx_q.pop_front(), rx);
    cs_end();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] rx;
    rd_q.delete();
    cs_begin();
    send_hdr(OP_READ, a);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      rd_q.push_back(rx);
    end
    cs_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3);
    mon_en = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus.spi_miso_oe); end
    checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", bus.spi_miso); end
    checks++; if (bus.wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe got=%b exp=0", bus.wr_strobe); end
    checks++; if (bus.cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", bus.cmd_err); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_write_read();
    int w0 = wr_cnt;
    tx_q = '{8'hA5, 8'h5A};
    do_write(24'h000010);
    checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=2", wr_cnt - w0); end
    do_read(24'h000010, 2);
    exp_q = '{8'hA5, 8'h5A};
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_q[i]) begin failures++; $display("FAIL wr_rd_byte%0d got=%02h exp=%02h", i, rd_q[i], exp_q[i]); end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_frame got=%b exp=0", bus.busy); end
  endtask

  task automatic test_wrap();
    int w0 = wr_cnt;
    tx_q = '{8'h11, 8'h22};
    do_write(24'h0000FF);
    checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=2", wr_cnt - w0); end
    do_read(24'h0000FF, 2);
    exp_q = '{8'h11, 8'h22};
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_rd_byte%0d got=%02h exp=%02h", i, rd_q[i], exp_q[i]); end
    end
    // Upper address bits must be discarded: 0xAB0000 aliases to 0x00.
    do_read(24'hAB0000, 1);
    checks++; if (rd_q[0] !== 8'h22) begin failures++; $display("FAIL wrap_mem0 got=%02h exp=22", rd_q[0]); end
  endtask

  task automatic test_bad_opcode();
    int e0 = err_cnt;
    int o0 = oe_cnt;
    logic [7:0] rx;
    cs_begin();
    send_hdr(8'h9F, 24'h000010);
    spi_byte(8'h00, rx);
    checks++; if (state_dbg !== ST_IGNORE) begin failures++; $display("FAIL bad_op_state got=%0d exp=%0d", state_dbg, ST_IGNORE); end
    cs_end();
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL bad_op_cmd_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (oe_cnt !== o0) begin failures++; $display("FAIL bad_op_oe_cycles got=%0d exp=0", oe_cnt - o0); end
    do_read(24'h000011, 1);
    checks++; if (rd_q[0] !== 8'h5A) begin failures++; $display("FAIL bad_op_next_read got=%02h exp=5a", rd_q[0]); end
  endtask

  task automatic test_partial_write();
    int w0;
    logic [7:0] rx;
    tx_q = '{8'hC3};
    do_write(24'h000020);
    w0 = wr_cnt;
    cs_begin();
    send_hdr(OP_WRITE, 24'h000020);
    spi_bits(8'h0F, 4, rx);
    wait_clk(4);
    bus.spi_cs_n = 1'b1;
    wait_clk(3);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy_3clk got=%b exp=0", bus.busy); end
    wait_clk(8);
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL abort_wr_strobe got=%0d exp=0", wr_cnt - w0); end
    do_read(24'h000020, 1);
    checks++; if (rd_q[0] !== 8'hC3) begin failures++; $display("FAIL abort_prior_content got=%02h exp=c3", rd_q[0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    cs_begin();
    send_hdr(OP_READ, 24'h000010);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL midrst_first_byte got=%02h exp=a5", rx); end
    spi_bits(8'h00, 3, rx);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", bus.spi_miso_oe); end
    checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", bus.spi_miso); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    spi_bits(8'hFF, 5, rx);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_no_resume got=%b exp=0", bus.busy); end
    cs_end();
    do_read(24'h000011, 1);
    checks++; if (rd_q[0] !== 8'h5A) begin failures++; $display("FAIL midrst_new_frame got=%02h exp=5a", rd_q[0]); end
  endtask

  task automatic test_back_to_back();
    int o0;
    tx_q = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    do_write(24'h000040);
    o0 = oe_cnt;
    do_read(24'h000040, 4);
    exp_q = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_byte%0d got=%02h exp=%02h", i, rd_q[i], exp_q[i]); end
    end
    checks++; if (oe_cnt <= o0) begin failures++; $display("FAIL stream_oe got=%0d exp=>0", oe_cnt - o0); end
  endtask

  task automatic test_fast_read();
    int e0 = err_cnt;
    logic [7:0] rx;
    cs_begin();
    send_hdr(OP_FAST_READ, 24'h000010);
    spi_byte(8'h00, rx);
`ifdef SPI_RESP_FAST_READ_EN
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL fast_read_b0 got=%02h exp=a5", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h5A) begin failures++; $display("FAIL fast_read_b1 got=%02h exp=5a", rx); end
    cs_end();
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL fast_read_cmd_err got=%0d exp=0", err_cnt - e0); end
`else
    checks++; if (state_dbg !== ST_IGNORE) begin failures++; $display("FAIL fast_off_state got=%0d exp=%0d", state_dbg, ST_IGNORE); end
    cs_end();
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL fast_off_cmd_err got=%0d exp=1", err_cnt - e0); end
`endif
  endtask

  task automatic test_miso_gating();
    checks++; if (leak_cnt !== 0) begin failures++; $display("FAIL miso_gated got=%0d exp=0", leak_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_bad_opcode();
    test_partial_write();
    test_reset_mid_read();
    test_back_to_back();
    test_fast_read();
    test_miso_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
